regfile_param: RTL



---
 rtl/regfile_param_if.sv | 25 ++
 rtl/regfile_param.sv | 89 ++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// Register-file access bus: two registered read ports, one write port and the
// sweep-done status flag. The requester side is master, the register file is slave.
interface regfile_param_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic                  Ready;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    input  ReadData1, ReadData2, Ready
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
    output ReadData1, ReadData2, Ready
  );
endinterface

// File: rtl/regfile_param.sv
// Parameterised 1W/2R register file: registered reads, clear-on-reset sweep and an
// optional hardwired zero register. Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
module regfile_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic           Clk,
  input  logic           Rst,
  regfile_param_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  state_t                stateNext;
  logic [ADDR_WIDTH-1:0] clearIdx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  isRun;
  logic                  writeEn;
  logic [DATA_WIDTH-1:0] rdNext1;
  logic [DATA_WIDTH-1:0] rdNext2;

  assign isRun   = (state == RUN);
  // Writes to entry 0 vanish when it is the hardwired zero register.
  assign writeEn = isRun && bus.RegWrite && !(ZERO_REG && (bus.WriteRegister == '0));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= CLEAR;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      CLEAR:   if (clearIdx == LAST_IDX) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = CLEAR;
    endcase
  end

  // Read-data selection; the zero-register rule overrides forwarding.
  always_comb begin
    rdNext1 = '0;
    rdNext2 = '0;
    if (isRun) begin
      rdNext1 = mem[bus.ReadRegister1];
      rdNext2 = mem[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
      if (writeEn && (bus.WriteRegister == bus.ReadRegister1)) rdNext1 = bus.WriteData;
      if (writeEn && (bus.WriteRegister == bus.ReadRegister2)) rdNext2 = bus.WriteData;
`endif
      if (ZERO_REG && (bus.ReadRegister1 == '0)) rdNext1 = '0;
      if (ZERO_REG && (bus.ReadRegister2 == '0)) rdNext2 = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      clearIdx      <= '0;
      bus.ReadData1 <= '0;
      bus.ReadData2 <= '0;
      bus.Ready     <= 1'b0;
    end else begin
      if (state == CLEAR) clearIdx <= ADDR_WIDTH'(clearIdx + 1'b1);
      bus.ReadData1 <= rdNext1;
      bus.ReadData2 <= rdNext2;
      bus.Ready     <= (stateNext == RUN);
    end
  end

  // Storage has no reset of its own; the sweep clears it one entry per cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == CLEAR) begin
        mem[clearIdx] <= '0;
      end else if (writeEn) begin
        mem[bus.WriteRegister] <= bus.WriteData;
      end
    end
  end

endmodule
